// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the PC sequencer: FSM states, next-PC sources and the PC step.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } pc_sel_e;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_branch_ctrl_branch_cond.sv
// Conditional-branch resolver: beq/bne against the ALU zero flag; purely combinational, no backpressure.
module branch_cond (
  input  logic beq,
  input  logic bne,
  input  logic zero,
  output logic br_taken
);

  // beq and bne together simply OR; the decoder never flags it as illegal.
  assign br_taken = (beq & zero) | (bne & ~zero);

endmodule

// File: rtl/pc_branch_ctrl.sv
// PC sequencer with boot/halt/fault FSM and saturating branch counters; PC updates one clock after
// the decision, taken/pc_plus4 are combinational; stall holds PC, counters and clears flush.
module pc_branch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             halt,
  input  logic             beq,
  input  logic             bne,
  input  logic             zero,
  input  logic             jump,
  input  logic             jr,
  input  logic [31:0]      imm_ext,
  input  logic [25:0]      jump_index,
  input  logic [31:0]      jr_target,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             fetch_valid,
  output logic             taken,
  output logic             flush,
  output logic             fault,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic        br_taken;
  logic        jr_misaligned;
  pc_sel_e     pc_sel;
  logic [31:0] pc_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  branch_cond u_branch_cond (
    .beq      (beq),
    .bne      (bne),
    .zero     (zero),
    .br_taken (br_taken)
  );

  assign pc_plus4      = pc_q + PC_STEP;
  assign jr_misaligned = (jr_target[1:0] != 2'b00);

  always_comb begin
    pc_sel = SEL_SEQ;
    if (jr)            pc_sel = SEL_JR;
    else if (jump)     pc_sel = SEL_J;
    else if (br_taken) pc_sel = SEL_BR;
  end

  always_comb begin
    pc_nxt = pc_plus4;
    case (pc_sel)
      SEL_JR:  pc_nxt = jr_target;
      SEL_J:   pc_nxt = {pc_plus4[31:28], jump_index, 2'b00};
      SEL_BR:  pc_nxt = pc_plus4 + (imm_ext << 2);
      default: pc_nxt = pc_plus4;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    flush_d      = 1'b0;
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (halt) begin
          state_d = ST_HALT;
        end else if (!stall) begin
          // A misaligned jr freezes the PC at the jr itself and is not counted.
          if (pc_sel == SEL_JR && jr_misaligned) begin
            state_d = ST_FAULT;
          end else begin
            pc_d    = pc_nxt;
            flush_d = (pc_sel != SEL_SEQ);
            if (beq | bne) branch_cnt_d = sat_inc(branch_cnt_q);
            if (br_taken)  taken_cnt_d  = sat_inc(taken_cnt_q);
          end
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      flush_q      <= 1'b0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      flush_q      <= flush_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = (state_q == ST_RUN);
  assign fault       = (state_q == ST_FAULT);
  assign taken       = (state_q == ST_RUN) & (br_taken | jump | jr);
  assign flush       = flush_q;
  assign branch_cnt  = branch_cnt_q;
  assign taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Directed bench for pc_branch_ctrl: table of single-cycle vectors plus reset, saturation, fault and halt sequences.
module tb_pc_branch_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int          CW  = 4;

  logic        clk = 1'b0;
  logic        rst, stall, halt, beq, bne, zero, jump, jr;
  logic [31:0] imm_ext, jr_target;
  logic [25:0] jump_index;
  logic [31:0] pc, pc_plus4;
  logic        fetch_valid, taken, flush, fault;
  logic [CW-1:0] branch_cnt, taken_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_branch_ctrl #(.RESET_PC(RPC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt), .beq(beq), .bne(bne),
    .zero(zero), .jump(jump), .jr(jr), .imm_ext(imm_ext), .jump_index(jump_index),
    .jr_target(jr_target), .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
    .taken(taken), .flush(flush), .fault(fault), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  typedef struct {
    logic        stall, halt, beq, bne, zero, jump, jr;
    logic [31:0] imm;
    logic [25:0] jidx;
    logic [31:0] jrt;
    logic        e_taken;
    logic [31:0] e_pp4;
    logic [31:0] e_pc;
    logic        e_flush;
    logic [3:0]  e_bc, e_tc;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic h, input logic bq, input logic bn, input logic z,
                       input logic j, input logic r, input logic [31:0] im, input logic [25:0] ji,
                       input logic [31:0] rt);
    stall = s; halt = h; beq = bq; bne = bn; zero = z; jump = j; jr = r;
    imm_ext = im; jump_index = ji; jr_target = rt;
  endtask

  task automatic chk_regs(input string tag, input logic [31:0] e_pc, input logic e_flush,
                          input logic e_fv, input logic e_fault, input logic [3:0] e_bc,
                          input logic [3:0] e_tc);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, e_flush});
    chk({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, e_fv});
    chk({tag, ".fault"}, {31'd0, fault}, {31'd0, e_fault});
    chk({tag, ".branch_cnt"}, {28'd0, branch_cnt}, {28'd0, e_bc});
    chk({tag, ".taken_cnt"}, {28'd0, taken_cnt}, {28'd0, e_tc});
  endtask

  initial begin
    //          st h bq bn z j r  imm           jidx        jrt            tk pp4            pc             fl bc tc
    vecs[0]  = '{0,0,0,0,0,0,1, 32'h0,         26'h0,      32'h0000_0200, 1, 32'h0000_010C, 32'h0000_0200, 1, 0, 0};
    vecs[1]  = '{0,0,1,0,1,0,0, 32'hFFFF_FFFE, 26'h0,      32'h0,         1, 32'h0000_0204, 32'h0000_01FC, 1, 1, 1};
    vecs[2]  = '{0,0,0,0,0,0,0, 32'h0,         26'h0,      32'h0,         0, 32'h0000_0200, 32'h0000_0200, 0, 1, 1};
    vecs[3]  = '{0,0,1,0,0,0,0, 32'hFFFF_FFFE, 26'h0,      32'h0,         0, 32'h0000_0204, 32'h0000_0204, 0, 2, 1};
    vecs[4]  = '{0,0,0,1,0,0,0, 32'h3,         26'h0,      32'h0,         1, 32'h0000_0208, 32'h0000_0214, 1, 3, 2};
    vecs[5]  = '{0,0,1,1,1,0,0, 32'h1,         26'h0,      32'h0,         1, 32'h0000_0218, 32'h0000_021C, 1, 4, 3};
    vecs[6]  = '{0,0,0,0,0,0,1, 32'h0,         26'h0,      32'h3000_0000, 1, 32'h0000_0220, 32'h3000_0000, 1, 4, 3};
    vecs[7]  = '{1,0,1,0,1,1,0, 32'h0,         26'h40,     32'h0,         1, 32'h3000_0004, 32'h3000_0000, 0, 4, 3};
    vecs[8]  = '{0,0,1,0,1,1,0, 32'h0,         26'h40,     32'h0,         1, 32'h3000_0004, 32'h3000_0100, 1, 5, 4};
    vecs[9]  = '{0,0,0,0,0,0,1, 32'h0,         26'h0,      32'hFFFF_FFF8, 1, 32'h3000_0104, 32'hFFFF_FFF8, 1, 5, 4};
    vecs[10] = '{0,0,0,1,0,0,0, 32'h1,         26'h0,      32'h0,         1, 32'hFFFF_FFFC, 32'h0000_0000, 1, 6, 5};
    vecs[11] = '{0,0,0,0,0,0,1, 32'h0,         26'h0,      32'hFFFF_FFFC, 1, 32'h0000_0004, 32'hFFFF_FFFC, 1, 6, 5};
    vecs[12] = '{0,0,0,0,0,0,0, 32'h0,         26'h0,      32'h0,         0, 32'h0000_0000, 32'h0000_0000, 0, 6, 5};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 0, 32'h0, 26'h3, 32'h0);
    repeat (2) @(posedge clk);
    #1 chk_regs("reset", RPC, 0, 0, 0, 0, 0);

    // BOOT ignores halt and instruction inputs
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, 1, 0, 1, 1, 0, 32'h5, 26'h3, 32'h0);
    #1 chk("boot.taken", {31'd0, taken}, 32'd0);
    chk("boot.fetch_valid", {31'd0, fetch_valid}, 32'd0);
    @(posedge clk);
    #1 chk_regs("boot_exit", RPC, 0, 1, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0);
    @(posedge clk);
    #1 chk("seq1.pc", pc, 32'h104);
    @(posedge clk);
    #1 chk("seq2.pc", pc, 32'h108);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].stall, vecs[i].halt, vecs[i].beq, vecs[i].bne, vecs[i].zero,
            vecs[i].jump, vecs[i].jr, vecs[i].imm, vecs[i].jidx, vecs[i].jrt);
      #1;
      chk($sformatf("vec%0d.taken", i), {31'd0, taken}, {31'd0, vecs[i].e_taken});
      chk($sformatf("vec%0d.pc_plus4", i), pc_plus4, vecs[i].e_pp4);
      @(posedge clk);
      #1 chk_regs($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_flush, 1, 0,
                  vecs[i].e_bc, vecs[i].e_tc);
    end

    // 20 taken bne from pc=0 with counters at 6/5: both pin at 4'hF
    for (int i = 0; i < 20; i++) begin
      logic [3:0] ebc, etc;
      ebc = (6 + i + 1 > 15) ? 4'hF : 4'(6 + i + 1);
      etc = (5 + i + 1 > 15) ? 4'hF : 4'(5 + i + 1);
      @(negedge clk);
      drive(0, 0, 0, 1, 0, 0, 0, 32'h0, 26'h0, 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d.branch_cnt", i), {28'd0, branch_cnt}, {28'd0, ebc});
      chk($sformatf("sat%0d.taken_cnt", i), {28'd0, taken_cnt}, {28'd0, etc});
      chk($sformatf("sat%0d.pc", i), pc, 32'(4 * (i + 1)));
    end

    // misaligned jr: fault, pc frozen at the jr address, no flush
    @(negedge clk);
    drive(0, 0, 1, 0, 1, 0, 1, 32'h0, 26'h0, 32'h0000_1002);
    @(posedge clk);
    #1 chk_regs("fault", 32'h50, 0, 0, 1, 4'hF, 4'hF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 1, 0, 1, 1, 32'h4, 26'h10, 32'h0000_2000);
      #1 chk($sformatf("fault_ign%0d.taken", i), {31'd0, taken}, 32'd0);
      @(posedge clk);
      #1 chk_regs($sformatf("fault_ign%0d", i), 32'h50, 0, 0, 1, 4'hF, 4'hF);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 chk_regs("fault_rst", RPC, 0, 0, 0, 0, 0);

    // halt wins over stall and branch; frozen until reset
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 0, 0, 32'h0, 26'h0, 32'h0);
    @(posedge clk);
    #1 chk_regs("pre_halt", 32'h104, 1, 1, 0, 1, 1);
    @(negedge clk);
    drive(1, 1, 0, 1, 0, 0, 0, 32'h8, 26'h0, 32'h0);
    @(posedge clk);
    #1 chk_regs("halt", 32'h104, 0, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 1, 0, 1, 0, 32'h8, 26'h22, 32'h0);
      #1 chk($sformatf("halt%0d.taken", i), {31'd0, taken}, 32'd0);
      @(posedge clk);
      #1 chk($sformatf("halt%0d.pc", i), pc, 32'h104);
      chk($sformatf("halt%0d.fetch_valid", i), {31'd0, fetch_valid}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 chk_regs("halt_rst", RPC, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
